// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the iterative multiplier.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 6
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   out;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, out
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, out
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Signed operands are converted to magnitudes on accept and the sign is
// reapplied to the final sum, so the core loop is always unsigned.
module seq_multiplier #(
  parameter int unsigned WIDTH = 6
) (
  input  logic            clk,
  input  logic            rst,
  seq_multiplier_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_d;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   out_q;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 sign;
  logic                 done_q;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last;

  // Operand magnitudes, partial-sum adder and final-iteration detect.
  always_comb begin
    mag_a   = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b   = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    acc_sum = acc + (mplier[0] ? mcand : '0);
    last    = (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic: accept in IDLE, leave RUN after WIDTH iterations.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (last)      state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, publish on the last edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      out_q  <= '0;
      mplier <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            sign   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            out_q  <= sign ? -acc_sum : acc_sum;
            done_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.out  = out_q;
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised iterative shift-add multiplier. It succeeds the fixed 6-bit unsigned unit with a configurable operand width, a per-operation signed/unsigned mode, an explicit start/busy/done handshake and an asynchronous reset. It sits beside the datapath ALU and serves operations where one bit per cycle is an acceptable multiply rate.

Parameters:
WIDTH, 6, operand width in bits; legal range is WIDTH >= 2.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when out is updated
out  output  2*WIDTH  product; holds its value until the next done

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; busy = 0, done = 0, out = 0; all internal registers cleared.
- A reset during RUN aborts the operation. No done is produced, and out = 0.
- States:
  - IDLE: busy = 0. If start = 1 at an edge (edge E0): latch a, b and is_signed, set the counter to 0, clear the accumulator, go to RUN.
  - RUN: busy = 1. Each edge performs one iteration:
    - if the multiplier LSB = 1, add the shifted multiplicand to the accumulator;
    - shift the multiplicand left by 1 and the multiplier right by 1;
    - increment the counter.
  - Exit from RUN: on the WIDTH-th RUN edge (EW), write the final sign-corrected product to out, set done = 1 for the following cycle, and return to IDLE.
- Latency: done and the new out are visible in the cycle after edge EW, i.e. WIDTH cycles after the accept edge. busy is high for exactly WIDTH cycles.
- done is a single-cycle pulse. It is low in every other cycle, including IDLE with start = 0.
- Back-to-back: start held high, or asserted during the done cycle, is accepted at the next edge because the block is already in IDLE. Throughput is one result per WIDTH+1 cycles with start held high.
- start while busy = 1 is ignored. Input changes during RUN have no effect, because operands are latched at E0.
- Arithmetic:
  - Accumulator and shifted multiplicand are 2*WIDTH bits wide; there is no overflow in either mode.
  - Unsigned mode: the product is exact in 2*WIDTH bits.
  - Signed mode: at E0, latch |a| and |b| as WIDTH-bit unsigned magnitudes and record sign = a[MSB] xor b[MSB]. At EW, out = sign ? -acc : acc (2*WIDTH two's complement).
  - The most-negative operand -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. (-2^(W-1))² = 2^(2W-2) is representable.
  - A zero operand gives out = 0 in both modes, with no negative-zero artefact.
- Counter width is clog2(WIDTH+1) bits. It never wraps within an operation.
- There is no combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=6, unsigned, a=63, b=63, one-cycle start pulse -> busy high 6 cycles; then done pulses once with out=12'hF81 (3969); out holds afterwards.
- WIDTH=6, signed, a=-5 (6'h3B), b=7 -> out=12'hFDD (-35); then signed a=-32, b=-32 -> out=12'h400 (1024); then signed a=-32, b=31 -> out=12'hC20 (-992).
- WIDTH=6, unsigned a=0, b=45, then signed a=-17, b=0 -> out=0 both times; done pulses each time.
- Start with a=10, b=3, then pulse start again with a=1, b=1 mid-RUN -> second request ignored; out=30 after 6 cycles; only one done pulse.
- Start held high continuously for three operations -> a done pulse every 7 cycles; busy low only in each done cycle; the three correct products appear in order.
- Start a=20, b=20; assert rst asynchronously (between edges) on the 3rd RUN cycle -> busy, done and out go to 0 immediately; no done pulse follows. After release, a=2, b=3 -> out=6.
- Parameter sweep WIDTH=2, 8, 16: random signed and unsigned operands against a reference model, including all corner operands (0, 1, max, min-negative) -> exact match and latency = WIDTH.
